// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Single full-adder cell with its carry flip-flop; the carry is seeded by load
// and advances by one bit position each cycle en is high.
module serial_fa_cell
  import serial_adder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_val,
  input  logic en,
  input  logic a_bit,
  input  logic b_bit,
  output logic s,
  output logic cout,
  output logic c_q
);

  assign s    = a_bit ^ b_bit ^ c_q;
  assign cout = (a_bit & b_bit) | (a_bit & c_q) | (b_bit & c_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= 1'b0;
    end else if (load) begin
      c_q <= load_val;
    end else if (en) begin
      c_q <= cout;
    end
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through one
// full-adder cell, so an operation takes WIDTH cycles between two handshakes.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   sum_sr;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               run;
  logic               s;
  logic               cout;
  logic               carry_state_unused;
  logic [WIDTH:0]     sum_cat;

  assign accept  = (state == ST_IDLE) && in_valid && in_ready;
  assign run     = (state == ST_RUN);
  // Concatenating the new bit above the register and dropping bit 0 keeps the
  // shift legal even when WIDTH is 1.
  assign sum_cat = {s, sum_sr};
  assign sum     = sum_sr;

  serial_fa_cell u_cell (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (ci),
    .en       (run),
    .a_bit    (a_sr[0]),
    .b_bit    (b_sr[0]),
    .s        (s),
    .cout     (cout),
    .c_q      (carry_state_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      cnt       <= '0;
      co        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            cnt      <= '0;
            state    <= ST_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_cat[WIDTH:1];
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            state     <= ST_DONE;
            co        <= cout;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 instance checked through a queue
// and a result monitor, plus a WIDTH=1 instance checked directly.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, ci, out_valid, out_ready, co, busy;
  logic [W-1:0] a, b, sum;
  logic         in_valid1, in_ready1, ci1, out_valid1, out_ready1, co1, busy1;
  logic [0:0]   a1, b1, sum1;

  int cyc = 0;
  int tests = 0;
  int failed = 0;
  int first_cyc = 0;
  logic ov_prev = 1'b0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           acc;
  } exp_t;
  exp_t sb[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .busy(busy)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .ci(ci1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .co(co1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one operation and returns the cycle whose closing edge accepted it.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ,
                               input logic [W-1:0] es, input logic ec, output int acc);
    exp_t e;
    bit   done;
    a = av; b = bv; ci = civ; in_valid = 1'b1;
    acc = -1;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc  = cyc;
        done = 1;
      end
    end
    if (!done) begin
      tests++; failed++;
      $display("[TB] FAIL accept timeout: got in_ready=0, expected 1");
    end else begin
      e.s = es; e.c = ec; e.acc = acc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) done = 1;
    end
    if (!done) begin
      tests++; failed++;
      $display("[TB] FAIL %s drain timeout: got %0d pending, expected 0", name, sb.size());
    end
  endtask

  // Result monitor: pops one expectation per output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && !ov_prev) first_cyc = cyc;
      ov_prev = out_valid;
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++; failed++;
          $display("[TB] FAIL unexpected result: got sum=0x%0h co=%0b, expected none", sum, co);
        end else begin
          e = sb.pop_front();
          checkOutput("sb sum", sum, e.s);
          checkOutput("sb co", co, e.c);
          checkOutput("sb latency", first_cyc - e.acc, W + 1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, first_acc, last_acc;
    logic [W-1:0] av, bv;
    logic         civ;
    logic [W:0]   model;
    bit           seen;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset sum", sum, 0);
    checkOutput("reset co", co, 0);
    checkOutput("reset busy", busy, 0);
    @(posedge clk); #1;

    // Cycle-exact latency of a single operation.
    applyStimulus(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, acc);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t1 out_valid c+%0d", k), out_valid, (k == 9));
      if (k == 8 || k == 10) checkOutput($sformatf("t1 in_ready c+%0d", k), in_ready, (k == 10));
    end
    @(posedge clk); #1;

    applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, acc);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, acc);
    waitDrain("t2");

    // Backpressure with noisy inputs while the result is held.
    out_ready = 1'b0;
    applyStimulus(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, acc);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checkOutput("t3 out_valid rise", seen, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid; a = a + 8'h11; b = ~b; ci = ~ci;
      @(negedge clk);
      checkOutput("t3 hold out_valid", out_valid, 1);
      checkOutput("t3 hold sum", sum, 8'h8D);
      checkOutput("t3 hold co", co, 0);
      checkOutput("t3 hold in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t3 release in_ready", in_ready, 1);
    checkOutput("t3 release out_valid", out_valid, 0);
    @(posedge clk); #1;

    // Reset on the 4th RUN edge aborts the operation.
    applyStimulus(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, acc);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("t4 in_ready", in_ready, 1);
    checkOutput("t4 out_valid", out_valid, 0);
    checkOutput("t4 sum", sum, 0);
    checkOutput("t4 co", co, 0);
    @(posedge clk); #1;
    applyStimulus(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, acc);
    waitDrain("t4");

    // Operand changes after acceptance must not leak into the result.
    applyStimulus(8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, acc);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
    end
    waitDrain("t5");

    // WIDTH=1 instance.
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; in_valid1 = 1'b1;
    @(negedge clk);
    checkOutput("w1 in_ready", in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    checkOutput("w1 out_valid c+1", out_valid1, 0);
    @(negedge clk);
    checkOutput("w1 out_valid c+2", out_valid1, 1);
    checkOutput("w1 sum", sum1, 1);
    checkOutput("w1 co", co1, 1);
    @(posedge clk); #1;

    // Back-to-back random operations against the arithmetic model.
    first_acc = 0; last_acc = 0;
    for (int n = 0; n < 1000; n++) begin
      av = 8'($urandom); bv = 8'($urandom); civ = 1'($urandom);
      model = {1'b0, av} + {1'b0, bv} + {8'd0, civ};
      applyStimulus(av, bv, civ, model[W-1:0], model[W], acc);
      if (n == 0) first_acc = acc;
      last_acc = acc;
    end
    waitDrain("random");
    checkOutput("random throughput", last_acc - first_acc, 999 * (W + 2));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single full-adder cell plus a registered carry.
- Accepts two parallel operands and a carry-in through a valid/ready handshake.
- Shifts the operands LSB-first through the cell, one bit per clock, and presents the parallel sum and carry-out through a second valid/ready handshake.
- Sits alongside the ripple adder as the area-minimal alternative: one adder cell, WIDTH cycles per operation.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..64
CNT_W, derived $clog2(WIDTH+1), bit-counter width; not overridable

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operands a, b, ci are valid
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
ci  input  1  carry-in for bit 0
out_valid  output  1  sum/co are valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  a + b + ci, low WIDTH bits
co  output  1  carry out of bit WIDTH-1
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at a rising edge), regardless of state:
  - state=IDLE; shift registers, carry flop and bit counter cleared.
  - Outputs: in_ready=1, out_valid=0, sum=0, co=0, busy=0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch a, b into shift registers; load carry flop with ci; counter=0; go to RUN.
  - sum/co keep the previous result until the first RUN edge.
- State RUN (in_ready=0, out_valid=0, busy=1):
  - Each cycle, the cell computes s = a_sr[0]^b_sr[0]^c and cout = majority(a_sr[0], b_sr[0], c).
  - s shifts into sum_sr MSB; a_sr and b_sr shift right; c <= cout; counter increments.
  - When counter reaches WIDTH-1 on this edge, go to DONE. co <= cout of that final bit.
- State DONE (out_valid=1, busy=1):
  - sum and co are held stable while out_valid=1 and out_ready=0, for any number of cycles.
  - On out_ready=1: go to IDLE next cycle.
  - No new operation is accepted in DONE. in_ready is low in RUN and DONE.
- Latency and throughput:
  - If the input handshake completes in cycle c, out_valid first rises in cycle c+WIDTH+1.
  - Maximum throughput is one operation per WIDTH+2 cycles.
- Width rules:
  - sum is exact modulo 2^WIDTH; co is bit WIDTH of a+b+ci.
  - No signed interpretation; overflow detection is the consumer's responsibility.
- Inputs ignored:
  - in_valid outside IDLE.
  - a, b, ci after the accept edge; changes to them do not affect the running operation.
- Reset mid-operation: the operation is aborted and its result is never presented. Next cycle is a normal IDLE.
- WIDTH=1: RUN lasts exactly one cycle.
- Protocol: out_valid never drops without out_ready; in_valid may drop without handshake.

Decomposition:
- Shared package serial_adder_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
- One sub-module: serial_fa_cell.
  - Combinational full-adder sum/majority carry plus the carry flip-flop with synchronous clear and load.
  - Ports: clk, rst, load, load_val, en, a_bit, b_bit, s, cout, c_q.
- Top level holds the FSM, counter, shift registers and handshakes.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x33, ci=0, accepted cycle c, out_ready=1 -> out_valid high in cycle c+9 only; sum=0x8D, co=0; in_ready back high in cycle c+10.
2. WIDTH=8, a=0xFF, b=0x01, ci=0 -> sum=0x00, co=1. Then a=0xFF, b=0xFF, ci=1 -> sum=0xFF, co=1.
3. Backpressure: after test 1 result, hold out_ready=0 for 5 cycles while toggling in_valid and changing a/b -> out_valid=1, sum=0x8D, co=0 stable, in_ready=0 throughout. Release -> IDLE next cycle.
4. Reset mid-run: accept a=0xAA, b=0x55, assert rst at the 4th RUN edge -> next cycle in_ready=1, out_valid=0, sum=0, co=0. Then a=0x10, b=0x20, ci=1 -> sum=0x31, co=0, with correct latency.
5. Input hold: change a/b/ci every cycle during RUN after accepting a=0x0F, b=0xF0, ci=1 -> result sum=0x00, co=1 (first operands only).
6. WIDTH=1 instance: a=1, b=1, ci=1 at cycle c -> out_valid at c+2, sum=1, co=1. Random 1000-op back-to-back run on WIDTH=8 against a reference model: all match, throughput one op per 10 cycles.
